// File: rtl/spu_wb_pkg.sv
// Shared widths and the buffered-result record for the SPU writeback stage.
package spu_wb_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 128;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rt;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Odd-pipe result buffer: circular FIFO with a parallel squash port and
// flattened rt/valid exports so the parent can answer hazard queries.
module wb_fifo #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [ADDR_W-1:0]        i_push_rt,
    input  logic [DATA_W-1:0]        i_push_data,
    input  logic                     i_pop,
    input  logic                     i_sq_en,
    input  logic [ADDR_W-1:0]        i_sq_rt,
    output logic                     o_head_vld,
    output logic [ADDR_W-1:0]        o_head_rt,
    output logic [DATA_W-1:0]        o_head_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [DEPTH-1:0]         o_vld,
    output logic [DEPTH*ADDR_W-1:0]  o_rt_flat
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_rd_ptr;
    logic [DEPTH-1:0]  r_vld;
    logic [ADDR_W-1:0] r_rt   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PW-1:0]     w_wr_idx;
    logic [PW-1:0]     w_rd_idx;

    assign w_wr_idx = r_wr_ptr[PW-1:0];
    assign w_rd_idx = r_rd_ptr[PW-1:0];

    // Valid bits double as occupancy-and-not-squashed, so they are cleared on pop.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_vld    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_sq_en && (r_rt[i] == i_sq_rt))
                    r_vld[i] <= 1'b0;
            end
            if (i_pop) begin
                r_vld[w_rd_idx] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + CW'(1);
            end
            if (i_push) begin
                r_vld[w_wr_idx] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_rt[w_wr_idx]   <= i_push_rt;
            r_data[w_wr_idx] <= i_push_data;
        end
    end

    assign o_head_vld  = r_vld[w_rd_idx];
    assign o_head_rt   = r_rt[w_rd_idx];
    assign o_head_data = r_data[w_rd_idx];
    assign o_count     = r_wr_ptr - r_rd_ptr;
    assign o_vld       = r_vld;

    always_comb begin
        o_rt_flat = '0;
        for (int i = 0; i < DEPTH; i++)
            o_rt_flat[i*ADDR_W +: ADDR_W] = r_rt[i];
    end

endmodule

// File: rtl/writeback_arbiter.sv
// SPU writeback: arbitrates even/odd pipe results onto the single register
// file write port, buffering odd results and answering decode hazard queries.
module writeback_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   even_valid,
    input  logic [ADDR_W-1:0]      even_rt,
    input  logic [DATA_W-1:0]      even_data,
    input  logic                   odd_valid,
    input  logic [ADDR_W-1:0]      odd_rt,
    input  logic [DATA_W-1:0]      odd_data,
    output logic                   odd_ready,
    output logic [ADDR_W-1:0]      registerRT,
    output logic [DATA_W-1:0]      writeData,
    output logic                   regWriteEnable,
    input  logic [ADDR_W-1:0]      query_ra,
    input  logic [ADDR_W-1:0]      query_rb,
    input  logic [ADDR_W-1:0]      query_rc,
    output logic                   hit_ra,
    output logic                   hit_rb,
    output logic                   hit_rc,
    output logic [$clog2(DEPTH):0] fifo_count
);

    import spu_wb_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    wb_entry_t               w_head;
    logic                    w_empty;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_bypass;
    logic                    w_we;
    logic [ADDR_W-1:0]       w_rt;
    logic [DATA_W-1:0]       w_data;
    logic [DEPTH-1:0]        w_vld;
    logic [DEPTH*ADDR_W-1:0] w_rt_flat;

    function automatic logic pending_hit(
        input logic [ADDR_W-1:0]       q,
        input logic [DEPTH-1:0]        vld,
        input logic [DEPTH*ADDR_W-1:0] rts,
        input logic                    we,
        input logic [ADDR_W-1:0]       wrt
    );
        logic h;
        h = we && (wrt == q);
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (rts[i*ADDR_W +: ADDR_W] == q))
                h = 1'b1;
        end
        return h;
    endfunction

    assign w_empty   = (fifo_count == '0);
    assign odd_ready = (fifo_count < DEPTH_C);

    // Even always wins; a buffered head beats a fresh odd result so odd order holds.
    always_comb begin
        w_we     = 1'b0;
        w_rt     = '0;
        w_data   = '0;
        w_pop    = 1'b0;
        w_bypass = 1'b0;
        if (even_valid) begin
            w_we   = 1'b1;
            w_rt   = even_rt;
            w_data = even_data;
        end else if (!w_empty) begin
            w_pop  = 1'b1;
            w_we   = w_head.valid;
            w_rt   = w_head.rt;
            w_data = w_head.data;
        end else if (odd_valid) begin
            w_bypass = 1'b1;
            w_we     = 1'b1;
            w_rt     = odd_rt;
            w_data   = odd_data;
        end
    end

    assign w_push = odd_valid && odd_ready && !w_bypass;

    wb_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .i_rst_n     (reset),
        .i_push      (w_push),
        .i_push_rt   (odd_rt),
        .i_push_data (odd_data),
        .i_pop       (w_pop),
        .i_sq_en     (even_valid),
        .i_sq_rt     (even_rt),
        .o_head_vld  (w_head.valid),
        .o_head_rt   (w_head.rt),
        .o_head_data (w_head.data),
        .o_count     (fifo_count),
        .o_vld       (w_vld),
        .o_rt_flat   (w_rt_flat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regWriteEnable <= 1'b0;
            registerRT     <= '0;
            writeData      <= '0;
        end else begin
            regWriteEnable <= w_we;
            registerRT     <= w_rt;
            writeData      <= w_data;
        end
    end

    assign hit_ra = pending_hit(query_ra, w_vld, w_rt_flat, regWriteEnable, registerRT);
    assign hit_rb = pending_hit(query_rb, w_vld, w_rt_flat, regWriteEnable, registerRT);
    assign hit_rc = pending_hit(query_rc, w_vld, w_rt_flat, regWriteEnable, registerRT);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: per-cycle vector table plus hand
// sequences for hazard hits and mid-operation reset.
module tb_writeback_arbiter;

    logic         clk;
    logic         reset;
    logic         even_valid;
    logic [6:0]   even_rt;
    logic [127:0] even_data;
    logic         odd_valid;
    logic [6:0]   odd_rt;
    logic [127:0] odd_data;
    logic         odd_ready;
    logic [6:0]   registerRT;
    logic [127:0] writeData;
    logic         regWriteEnable;
    logic [6:0]   query_ra;
    logic [6:0]   query_rb;
    logic [6:0]   query_rc;
    logic         hit_ra;
    logic         hit_rb;
    logic         hit_rc;
    logic [2:0]   fifo_count;

    int n_checks;
    int n_fail;

    writeback_arbiter #(.ADDR_W(7), .DATA_W(128), .DEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .even_valid     (even_valid),
        .even_rt        (even_rt),
        .even_data      (even_data),
        .odd_valid      (odd_valid),
        .odd_rt         (odd_rt),
        .odd_data       (odd_data),
        .odd_ready      (odd_ready),
        .registerRT     (registerRT),
        .writeData      (writeData),
        .regWriteEnable (regWriteEnable),
        .query_ra       (query_ra),
        .query_rb       (query_rb),
        .query_rc       (query_rc),
        .hit_ra         (hit_ra),
        .hit_rb         (hit_rb),
        .hit_rc         (hit_rc),
        .fifo_count     (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         ev;
        logic [6:0]   ert;
        logic [127:0] ed;
        logic         ov;
        logic [6:0]   ort;
        logic [127:0] od;
        logic         xwe;
        logic [6:0]   xrt;
        logic [127:0] xd;
        logic [2:0]   xcnt;
        logic         xrdy;
    } vec_t;

    vec_t vt[$];

    function automatic logic [127:0] dat(input logic [7:0] b);
        return {16{b}};
    endfunction

    function automatic vec_t mk(
        input logic ev, input logic [6:0] ert, input logic [127:0] ed,
        input logic ov, input logic [6:0] ort, input logic [127:0] od,
        input logic xwe, input logic [6:0] xrt, input logic [127:0] xd,
        input logic [2:0] xcnt, input logic xrdy);
        vec_t v;
        v.ev = ev; v.ert = ert; v.ed = ed;
        v.ov = ov; v.ort = ort; v.od = od;
        v.xwe = xwe; v.xrt = xrt; v.xd = xd;
        v.xcnt = xcnt; v.xrdy = xrdy;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [6:0] ert, input logic [127:0] ed,
                         input logic ov, input logic [6:0] ort, input logic [127:0] od);
        even_valid = ev; even_rt = ert; even_data = ed;
        odd_valid  = ov; odd_rt  = ort; odd_data  = od;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        query_ra = '0;
        query_rb = '0;
        query_rc = '0;
        drive(0, 0, 0, 0, 0, 0);

        // Single bypass, even/odd collision, fill to full, drain, squash, same-rt, push+pop.
        vt.push_back(mk(0, 0, 0,          1, 5, dat(8'hA5), 1, 5, dat(8'hA5), 0, 1));
        vt.push_back(mk(0, 0, 0,          0, 0, 0,         0, 0, 0,          0, 1));
        vt.push_back(mk(1, 3, dat(8'hE3), 1, 9, dat(8'h09), 1, 3, dat(8'hE3), 1, 1));
        vt.push_back(mk(0, 0, 0,          0, 0, 0,         1, 9, dat(8'h09), 0, 1));
        for (int k = 0; k < 4; k++)
            vt.push_back(mk(1, 7'(10 + k), dat(8'(10 + k)), 1, 7'(20 + k), dat(8'(20 + k)),
                            1, 7'(10 + k), dat(8'(10 + k)), 3'(k + 1), (k < 3)));
        vt.push_back(mk(0, 0, 0,          1, 30, dat(8'h30), 1, 20, dat(8'd20), 3, 1));
        vt.push_back(mk(0, 0, 0,          0, 0, 0,         1, 21, dat(8'd21), 2, 1));
        vt.push_back(mk(0, 0, 0,          0, 0, 0,         1, 22, dat(8'd22), 1, 1));
        vt.push_back(mk(0, 0, 0,          0, 0, 0,         1, 23, dat(8'd23), 0, 1));
        vt.push_back(mk(0, 0, 0,          0, 0, 0,         0, 0, 0,          0, 1));
        vt.push_back(mk(1, 1, dat(8'h01), 1, 12, dat(8'hBD), 1, 1, dat(8'h01), 1, 1));
        vt.push_back(mk(1, 12, 128'h1,    0, 0, 0,         1, 12, 128'h1,    1, 1));
        vt.push_back(mk(0, 0, 0,          0, 0, 0,         0, 0, 0,          0, 1));
        vt.push_back(mk(0, 0, 0,          0, 0, 0,         0, 0, 0,          0, 1));
        vt.push_back(mk(1, 40, dat(8'hE4), 1, 40, dat(8'hD4), 1, 40, dat(8'hE4), 1, 1));
        vt.push_back(mk(0, 0, 0,          0, 0, 0,         1, 40, dat(8'hD4), 0, 1));
        vt.push_back(mk(1, 2, dat(8'h02), 1, 50, dat(8'h50), 1, 2, dat(8'h02), 1, 1));
        vt.push_back(mk(0, 0, 0,          1, 51, dat(8'h51), 1, 50, dat(8'h50), 1, 1));
        vt.push_back(mk(0, 0, 0,          0, 0, 0,         1, 51, dat(8'h51), 0, 1));

        #1;
        check("rst_we",    regWriteEnable, 0);
        check("rst_rt",    registerRT, 0);
        check("rst_data",  writeData, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", odd_ready, 1);
        check("rst_hit_ra", hit_ra, 0);
        #11;
        reset = 1'b1;
        step();

        foreach (vt[i]) begin
            drive(vt[i].ev, vt[i].ert, vt[i].ed, vt[i].ov, vt[i].ort, vt[i].od);
            step();
            check($sformatf("v%0d_we", i), regWriteEnable, vt[i].xwe);
            if (vt[i].xwe) begin
                check($sformatf("v%0d_rt", i), registerRT, vt[i].xrt);
                check($sformatf("v%0d_data", i), writeData, vt[i].xd);
            end
            check($sformatf("v%0d_count", i), fifo_count, vt[i].xcnt);
            check($sformatf("v%0d_ready", i), odd_ready, vt[i].xrdy);
        end

        // Hazard hits: same-cycle push invisible, pending, write cycle, then clear.
        query_ra = 21; query_rb = 20; query_rc = 4;
        drive(1, 4, dat(8'h44), 1, 20, dat(8'h20));
        #1;
        check("hit_rb_same_cycle", hit_rb, 0);
        check("hit_rc_same_cycle", hit_rc, 0);
        step();
        check("hit_rb_pending", hit_rb, 1);
        check("hit_ra_pending", hit_ra, 0);
        check("hit_rc_output",  hit_rc, 1);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("hit_rb_write",   hit_rb, 1);
        check("hit_ra_write",   hit_ra, 0);
        check("hit_rc_after",   hit_rc, 0);
        check("hit_rt_write",   registerRT, 20);
        step();
        check("hit_rb_done",    hit_rb, 0);
        check("hit_ra_done",    hit_ra, 0);

        // Reset with three buffered entries.
        for (int k = 0; k < 3; k++) begin
            drive(1, 7'(60 + k), dat(8'(60 + k)), 1, 7'(70 + k), dat(8'(70 + k)));
            step();
        end
        check("pre_rst_count", fifo_count, 3);
        drive(0, 0, 0, 0, 0, 0);
        query_ra = 70;
        #2;
        reset = 1'b0;
        #1;
        check("arst_count", fifo_count, 0);
        check("arst_we",    regWriteEnable, 0);
        check("arst_ready", odd_ready, 1);
        check("arst_hit_ra", hit_ra, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("post_rst_we%0d", k), regWriteEnable, 0);
            check($sformatf("post_rst_count%0d", k), fifo_count, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
